// File: rtl/sram_access_sequencer.sv
// Read/write burst sequencer sharing one single-port SRAM macro.
// Define SRAM_SEQ_RR_EN for round-robin arbitration (default: write wins ties).
module sram_access_sequencer #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_dvalid,
  output logic              rd_last,
  input  logic              rd_ready,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              wr_gnt,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic              wr_bvalid,
  output logic              wr_bready,
  output logic              wr_done,
  output logic              CEB,
  output logic              WEB,
  output logic [DATA_W-1:0] BWEB,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] Q
);

  localparam int SW = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    RD_BURST,
    RD_DRAIN,
    WR_BURST
  } state_e;

  state_e              state_q, state_d;
  logic                sel_rd_q, sel_rd_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_dvalid_q, rd_dvalid_d;
  logic                rd_last_q, rd_last_d;
  logic                wr_done_q, wr_done_d;
  logic                issue, accept, pick_rd;
  logic                ceb, web;
  logic [DATA_W-1:0]   bweb, dout, strb_mask;

`ifdef SRAM_SEQ_RR_EN
  logic last_wr_q, last_wr_d;

  // Ties go to whichever class was not granted last.
  assign pick_rd = rd_req & (~wr_req | last_wr_q);

  always_comb begin
    last_wr_d = last_wr_q;
    if (state_q == IDLE && (rd_req || wr_req)) last_wr_d = ~pick_rd;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) last_wr_q <= 1'b1;
    else          last_wr_q <= last_wr_d;
  end
`else
  assign pick_rd = rd_req & ~wr_req;
`endif

  always_comb begin
    strb_mask = '0;
    for (int i = 0; i < SW; i++) begin
      strb_mask[8*i +: 8] = {8{wr_strb[i]}};
    end
  end

  assign issue  = ~rd_dvalid_q | rd_ready;
  assign accept = rd_dvalid_q & rd_ready;

  always_comb begin
    state_d     = state_q;
    sel_rd_d    = sel_rd_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    rd_data_d   = rd_data_q;
    rd_dvalid_d = rd_dvalid_q;
    rd_last_d   = rd_last_q;
    wr_done_d   = 1'b0;
    ceb         = 1'b1;
    web         = 1'b1;
    bweb        = '1;
    dout        = '0;
    rd_gnt      = 1'b0;
    wr_gnt      = 1'b0;
    wr_bready   = 1'b0;
    if (accept) rd_dvalid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_req || wr_req) begin
          sel_rd_d = pick_rd;
          cnt_d    = pick_rd ? rd_len : wr_len;
          ptr_d    = pick_rd ? rd_addr : wr_addr;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        rd_gnt  = sel_rd_q;
        wr_gnt  = ~sel_rd_q;
        state_d = sel_rd_q ? RD_BURST : WR_BURST;
      end
      RD_BURST: begin
        if (issue) begin
          ceb         = 1'b0;
          rd_data_d   = Q;
          rd_dvalid_d = 1'b1;
          rd_last_d   = (cnt_q == '0);
          if (cnt_q == '0) begin
            state_d = RD_DRAIN;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      RD_DRAIN: begin
        if (accept && rd_last_q) state_d = IDLE;
      end
      WR_BURST: begin
        wr_bready = 1'b1;
        if (wr_bvalid) begin
          ceb  = 1'b0;
          web  = 1'b0;
          dout = wr_data;
          bweb = ~strb_mask;
          if (cnt_q == '0) begin
            wr_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      sel_rd_q    <= 1'b0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      rd_data_q   <= '0;
      rd_dvalid_q <= 1'b0;
      rd_last_q   <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_rd_q    <= sel_rd_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      rd_data_q   <= rd_data_d;
      rd_dvalid_q <= rd_dvalid_d;
      rd_last_q   <= rd_last_d;
      wr_done_q   <= wr_done_d;
    end
  end

  // Macro is disabled the instant reset asserts, independent of state decode.
  assign CEB       = ceb | ~ARESETn;
  assign WEB       = web;
  assign BWEB      = bweb;
  assign A         = ptr_q;
  assign D         = dout;
  assign rd_data   = rd_data_q;
  assign rd_dvalid = rd_dvalid_q;
  assign rd_last   = rd_last_q;
  assign wr_done   = wr_done_q;

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Directed bench for sram_access_sequencer with a behavioural SRAM macro
// and scoreboards for macro writes and returned read beats.
module tb_sram_access_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        rd_req = 0, rd_ready = 0;
  logic [13:0] rd_addr = 0;
  logic [3:0]  rd_len = 0;
  logic        rd_gnt, rd_dvalid, rd_last;
  logic [31:0] rd_data;
  logic        wr_req = 0, wr_bvalid = 0;
  logic [13:0] wr_addr = 0;
  logic [3:0]  wr_len = 0;
  logic [31:0] wr_data = 0;
  logic [3:0]  wr_strb = 0;
  logic        wr_gnt, wr_bready, wr_done;
  logic        CEB, WEB;
  logic [31:0] BWEB, D, Q;
  logic [13:0] A;

  sram_access_sequencer dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_dvalid(rd_dvalid),
    .rd_last(rd_last), .rd_ready(rd_ready),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_gnt(wr_gnt), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_bvalid(wr_bvalid), .wr_bready(wr_bready), .wr_done(wr_done),
    .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .D(D), .Q(Q)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [13:0] a;
    logic [31:0] bweb;
    logic [31:0] d;
  } wexp_t;

  logic [31:0] mem [0:16383];
  logic [31:0] ref_mem [0:16383];
  wexp_t       wr_q [$];
  logic [32:0] rd_q [$];
  wexp_t       we;
  logic [32:0] re;
  int          pass_cnt = 0, fail_cnt = 0, tot_cnt = 0;
  bit          m_last_wr = 1'b1;
  bit          e1, e2, e3;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Macro model: samples pins on the falling edge.
  always @(negedge ACLK) begin
    if (!CEB) begin
      if (!WEB) mem[A] <= (mem[A] & BWEB) | (D & ~BWEB);
      else      Q <= mem[A];
    end
  end

  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (!CEB && !WEB) begin
        if (wr_q.size() == 0) chk("wr_unexpected", {63'd0, ~CEB}, 64'd0);
        else begin
          we = wr_q.pop_front();
          chk("wr_A", A, we.a);
          chk("wr_BWEB", BWEB, we.bweb);
          chk("wr_D", D, we.d);
        end
      end
      if (rd_dvalid && rd_ready) begin
        if (rd_q.size() == 0) chk("rd_unexpected", rd_dvalid, 0);
        else begin
          re = rd_q.pop_front();
          chk("rd_data", rd_data, re[31:0]);
          chk("rd_last", rd_last, re[32]);
        end
      end
    end
  end

  function automatic bit exp_win(input bit r, input bit w);
`ifdef SRAM_SEQ_RR_EN
    return r & (!w | m_last_wr);
`else
    return r & !w;
`endif
  endfunction

  task automatic chk_reset(input string t);
    chk({t, "_CEB"}, CEB, 1);
    chk({t, "_WEB"}, WEB, 1);
    chk({t, "_BWEB"}, BWEB, 32'hFFFF_FFFF);
    chk({t, "_A"}, A, 0);
    chk({t, "_D"}, D, 0);
    chk({t, "_rd_gnt"}, rd_gnt, 0);
    chk({t, "_rd_dvalid"}, rd_dvalid, 0);
    chk({t, "_rd_last"}, rd_last, 0);
    chk({t, "_rd_data"}, rd_data, 0);
    chk({t, "_wr_gnt"}, wr_gnt, 0);
    chk({t, "_wr_bready"}, wr_bready, 0);
    chk({t, "_wr_done"}, wr_done, 0);
  endtask

  task automatic req(input bit is_rd, input logic [13:0] a,
                     input logic [3:0] l);
    if (is_rd) begin
      rd_req = 1; rd_addr = a; rd_len = l;
    end else begin
      wr_req = 1; wr_addr = a; wr_len = l;
    end
  endtask

  task automatic grant_wait(input bit exp_rd);
    int  n;
    bit  got;
    n = 0;
    got = 0;
    while (!got && n < 20) begin
      @(negedge ACLK);
      n++;
      if (rd_gnt || wr_gnt) got = 1;
    end
    chk("gnt_seen", got, 1);
    if (got) begin
      chk("gnt_rd", rd_gnt, exp_rd);
      chk("gnt_wr", wr_gnt, !exp_rd);
    end
    m_last_wr = !exp_rd;
  endtask

  // Runs a granted burst; entered at the GRANT negedge, exits at the IDLE negedge.
  task automatic serve(input bit is_rd, input logic [13:0] a,
                       input logic [3:0] l, input logic [3:0] s,
                       input logic [31:0] base, input int stall_at);
    int acc, cyc, stall_n;
    logic [13:0] ai;
    logic [31:0] bw, dd;
    if (is_rd) begin
      for (int i = 0; i <= int'(l); i++) begin
        ai = a + 14'(i);
        rd_q.push_back({(i == int'(l)), ref_mem[ai]});
      end
      @(posedge ACLK); #1;
      rd_req = 0;
      rd_ready = 1;
      @(negedge ACLK);
      chk("rd_issue_CEB", CEB, 0);
      chk("rd_issue_WEB", WEB, 1);
      chk("rd_issue_A", A, a);
      acc = 0; cyc = 0; stall_n = 0;
      while (acc <= int'(l) && cyc < 40) begin
        @(posedge ACLK); #1;
        rd_ready = !(stall_at != 0 && acc == stall_at - 1 && stall_n < 3);
        @(negedge ACLK);
        cyc++;
        if (cyc == 1) chk("rd_latency", rd_dvalid, 1);
        if (!rd_ready) begin
          stall_n++;
          chk("stall_CEB", CEB, 1);
          chk("stall_dvalid", rd_dvalid, 1);
          chk("stall_data", rd_data, ref_mem[a + 14'(stall_at - 1)]);
        end
        if (rd_dvalid && rd_ready) acc++;
      end
      chk("rd_beats", acc, int'(l) + 1);
      if (stall_at == 0) chk("rd_consecutive", cyc, int'(l) + 1);
      else chk("rd_stall_cycles", stall_n, 3);
      @(posedge ACLK); #1;
      @(negedge ACLK);
      chk("rd_idle_dvalid", rd_dvalid, 0);
    end else begin
      @(posedge ACLK); #1;
      wr_req = 0;
      for (int i = 0; i <= int'(l); i++) begin
        ai = a + 14'(i);
        dd = base ^ 32'(i);
        bw = {{8{~s[3]}}, {8{~s[2]}}, {8{~s[1]}}, {8{~s[0]}}};
        wr_bvalid = 1; wr_data = dd; wr_strb = s;
        wr_q.push_back('{ai, bw, dd});
        ref_mem[ai] = (ref_mem[ai] & bw) | (dd & ~bw);
        @(negedge ACLK);
        chk("wr_bready", wr_bready, 1);
        @(posedge ACLK); #1;
      end
      wr_bvalid = 0;
      @(negedge ACLK);
      chk("wr_done", wr_done, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    repeat (2) @(posedge ACLK);
    #1;
    chk_reset("rst");
    @(posedge ACLK); #1;
    ARESETn = 1;
    @(negedge ACLK);
    chk_reset("idle");

    req(0, 14'h010, 0);
    grant_wait(0);
    serve(0, 14'h010, 0, 4'hF, 32'hDEAD_BEEF, 0);
    @(negedge ACLK);
    chk("wr_done_pulse", wr_done, 0);

    req(0, 14'h011, 2);
    grant_wait(0);
    serve(0, 14'h011, 2, 4'hF, 32'h1111_0000, 0);

    req(0, 14'h3FFE, 3);
    grant_wait(0);
    serve(0, 14'h3FFE, 3, 4'b0101, 32'hA5A5_5A5A, 0);
    @(negedge ACLK);
    chk("wrap_done_pulse", wr_done, 0);

    req(1, 14'h3FFE, 3);
    grant_wait(1);
    serve(1, 14'h3FFE, 3, 4'h0, 32'h0, 0);

    req(1, 14'h010, 3);
    grant_wait(1);
    serve(1, 14'h010, 3, 4'h0, 32'h0, 0);

    req(1, 14'h010, 3);
    grant_wait(1);
    serve(1, 14'h010, 3, 4'h0, 32'h0, 2);

    req(0, 14'h020, 1);
    grant_wait(0);
    serve(0, 14'h020, 1, 4'b0000, 32'h7777_7777, 0);

    req(1, 14'h010, 1);
    req(0, 14'h030, 1);
    e1 = exp_win(1, 1);
    grant_wait(e1);
    serve(e1, e1 ? 14'h010 : 14'h030, 1, 4'hF, 32'hC0DE_0000, 0);
    req(e1, e1 ? 14'h010 : 14'h030, 1);
    e2 = exp_win(1, 1);
    grant_wait(e2);
    serve(e2, e2 ? 14'h010 : 14'h030, 1, 4'hF, 32'hC0DE_1000, 0);
    e3 = !e2;
    grant_wait(e3);
    serve(e3, e3 ? 14'h010 : 14'h030, 1, 4'hF, 32'hC0DE_2000, 0);

    req(0, 14'h200, 3);
    grant_wait(0);
    @(posedge ACLK); #1;
    wr_req = 0;
    wr_bvalid = 1; wr_data = 32'h600D_0000; wr_strb = 4'hF;
    wr_q.push_back('{14'h200, 32'h0, 32'h600D_0000});
    ref_mem[14'h200] = 32'h600D_0000;
    @(negedge ACLK);
    chk("rst_beat0_bready", wr_bready, 1);
    @(posedge ACLK); #1;
    wr_data = 32'h0BAD_0001;
    #1 ARESETn = 0;
    #1 chk_reset("midrst");
    wr_bvalid = 0;
    m_last_wr = 1'b1;
    @(posedge ACLK); #1;
    ARESETn = 1;
    @(negedge ACLK);
    chk_reset("postrst");
    req(1, 14'h200, 1);
    grant_wait(1);
    serve(1, 14'h200, 1, 4'h0, 32'h0, 0);

    chk("wr_queue_empty", wr_q.size(), 0);
    chk("rd_queue_empty", rd_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
